// File: rtl/rgb_hue_pkg.sv
// Shared types and the hue-wheel duty function for the RGB colour sequencer.
// Duties are produced at the widest supported resolution and then narrowed.
package rgb_hue_pkg;

  typedef enum logic [2:0] {
    SEG_RY = 3'd0,
    SEG_YG = 3'd1,
    SEG_GC = 3'd2,
    SEG_CB = 3'd3,
    SEG_BM = 3'd4,
    SEG_MR = 3'd5
  } seg_t;

  localparam int NUM_SEGS     = 6;
  localparam int MAX_PWM_BITS = 12;
  localparam int DUTY_W       = MAX_PWM_BITS + 1;

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } duty_t;

  // STEP mode behaves as FADE with the ramp pinned at zero.
  function automatic duty_t hue_duty(input seg_t seg, input logic [MAX_PWM_BITS-1:0] lvl,
                                     input logic fade, input int unsigned width);
    duty_t             d;
    logic [DUTY_W-1:0] full;
    logic [DUTY_W-1:0] ramp;
    logic [DUTY_W-1:0] fall;
    full = DUTY_W'(1) << width;
    ramp = fade ? {1'b0, lvl} : '0;
    fall = full - ramp;
    d    = '0;
    case (seg)
      SEG_RY: begin d.r = full; d.g = ramp; end
      SEG_YG: begin d.r = fall; d.g = full; end
      SEG_GC: begin d.g = full; d.b = ramp; end
      SEG_CB: begin d.g = fall; d.b = full; end
      SEG_BM: begin d.r = ramp; d.b = full; end
      SEG_MR: begin d.r = full; d.b = fall; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter shared by three registered duty comparators.
// lit[2]=red, lit[1]=green, lit[0]=blue, active high.
module pwm_gen
  import rgb_hue_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3*DUTY_W-1:0] duty,
  output logic [2:0]          lit
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic [2:0]          lit_q;
  logic [2:0]          lit_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  // A duty of 2^PWM_BITS exceeds every count, so FULL is continuously lit.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign lit_d[gi] = duty[gi*DUTY_W +: DUTY_W] > DUTY_W'(pwm_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      lit_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      lit_q     <= lit_d;
    end
  end

  assign lit = lit_q;

endmodule

// File: rtl/rgb_hue_seq.sv
// Hue-wheel colour sequencer: prescaler -> level ramp -> segment counter,
// with per-segment duties fed to a PWM stage driving active-low RGB pads.
module rgb_hue_seq
  import rgb_hue_pkg::*;
#(
  parameter int STEP_CYCLES = 7812,
  parameter int PWM_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  output logic [2:0] seg,
  output logic       seg_tick,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B
);

  localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  if (STEP_CYCLES < 1 || PWM_BITS < 2 || PWM_BITS > MAX_PWM_BITS) begin : g_bad_param
    $error("rgb_hue_seq: STEP_CYCLES must be >=1 and PWM_BITS in 2..12");
  end

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [PWM_BITS-1:0]     lvl_q, lvl_d;
  seg_t                    seg_q, seg_d;
  logic                    seg_tick_q, seg_tick_d;
  logic [MAX_PWM_BITS-1:0] lvl_ext;
  duty_t                   duty;
  logic [2:0]              lit;

  always_comb begin
    pre_d      = pre_q;
    lvl_d      = lvl_q;
    seg_d      = seg_q;
    seg_tick_d = 1'b0;
    if (en) begin
      if (pre_q == PRE_W'(STEP_CYCLES - 1)) begin
        pre_d = '0;
        lvl_d = lvl_q + 1'b1;
        if (lvl_q == '1) begin
          seg_tick_d = 1'b1;
          seg_d      = (seg_q == SEG_MR) ? SEG_RY : seg_t'(seg_q + 3'd1);
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      lvl_q      <= '0;
      seg_q      <= SEG_RY;
      seg_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      lvl_q      <= lvl_d;
      seg_q      <= seg_d;
      seg_tick_q <= seg_tick_d;
    end
  end

  // Duties follow mode combinationally; the PWM register adds the one-cycle lag.
  always_comb begin
    lvl_ext                 = '0;
    lvl_ext[PWM_BITS-1:0]   = lvl_q;
    duty                    = hue_duty(seg_q, lvl_ext, mode, PWM_BITS);
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .duty ({duty.r, duty.g, duty.b}),
    .lit  (lit)
  );

  assign seg      = seg_q;
  assign seg_tick = seg_tick_q;
  assign RGB_R    = ~lit[2];
  assign RGB_G    = ~lit[1];
  assign RGB_B    = ~lit[0];

endmodule

// File: tb/tb_rgb_hue_seq.sv
// Directed bench for rgb_hue_seq with PWM_BITS=3, STEP_CYCLES=2 (16-cycle segments).
module tb_rgb_hue_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] seg;
  logic       seg_tick;
  logic       RGB_R, RGB_G, RGB_B;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int pos      = 0;  // enabled edges since reset, modulo one wheel (96)

  rgb_hue_seq #(
    .STEP_CYCLES(2),
    .PWM_BITS   (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .seg     (seg),
    .seg_tick(seg_tick),
    .RGB_R   (RGB_R),
    .RGB_G   (RGB_G),
    .RGB_B   (RGB_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("  vec %0d %s = %0d", vec_cnt, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_en(input int n);
    en = 1'b1;
    repeat (n) begin
      tick();
      pos = (pos + 1) % 96;
    end
  endtask

  task automatic advance_to(input int s, input int l);
    run_en((s * 16 + l * 2 - pos + 96) % 96);
  endtask

  // Freeze the sequence and count lit cycles per channel over n cycles.
  task automatic count_lit(input int n, output int r, output int g, output int b);
    en = 1'b0;
    r = 0; g = 0; b = 0;
    repeat (n) begin
      tick();
      r += int'(!RGB_R);
      g += int'(!RGB_G);
      b += int'(!RGB_B);
    end
  endtask

  function automatic int pads();
    return int'({RGB_R, RGB_G, RGB_B});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, b, n, ticks, off, bad;

    // Reset hold and release
    rst_n = 1'b0; en = 1'b1; mode = 1'b0;
    #12;
    check_eq("reset_pads", pads(), 7);
    check_eq("reset_seg", int'(seg), 0);
    check_eq("reset_tick", int'(seg_tick), 0);
    #10 rst_n = 1'b1;
    run_en(1);
    check_eq("first_edge_pads", pads(), 3);

    // STEP sequence over one full wheel
    ticks = 0; off = 0;
    for (int i = 2; i <= 96; i++) begin
      run_en(1);
      if (seg_tick) begin
        ticks++;
        if (i % 16 != 0) off++;
      end
      if (i % 16 == 0) begin
        check_eq($sformatf("step_seg@%0d", i), int'(seg), (i / 16) % 6);
        check_eq($sformatf("step_tick@%0d", i), int'(seg_tick), 1);
      end
      if (i == 20) check_eq("step_seg1_pads", pads(), 1);
      if (i == 52) check_eq("step_seg3_pads", pads(), 4);
    end
    check_eq("step_tick_total", ticks, 6);
    check_eq("step_tick_offgrid", off, 0);

    // FADE duty in seg0 and seg1 at lvl=3
    mode = 1'b1;
    advance_to(0, 3);
    count_lit(8, r, g, b);
    check_eq("fade_s0_r_lit", r, 8);
    check_eq("fade_s0_g_lit", g, 3);
    check_eq("fade_s0_b_lit", b, 0);
    advance_to(1, 3);
    check_eq("fade_s1_seg", int'(seg), 1);
    count_lit(8, r, g, b);
    check_eq("fade_s1_r_lit", r, 5);
    check_eq("fade_s1_g_lit", g, 8);

    // Pause 40 cycles mid-seg2
    advance_to(2, 3);
    en = 1'b0; b = 0; bad = 0;
    repeat (40) begin
      tick();
      b += int'(!RGB_B);
      if (seg != 3'd2 || seg_tick) bad++;
    end
    check_eq("pause_frozen_errs", bad, 0);
    check_eq("pause_b_lit", b, 15);
    en = 1'b1; n = 0;
    while (!seg_tick && n < 200) begin
      tick();
      n++;
    end
    check_eq("pause_resume_edges", n, 10);
    check_eq("pause_resume_seg", int'(seg), 3);
    pos = 48;

    // Asynchronous reset mid-seg3
    advance_to(3, 4);
    check_eq("prereset_b", int'(RGB_B), 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_pads", pads(), 7);
    check_eq("async_reset_seg", int'(seg), 0);
    rst_n = 1'b1;
    pos = 0;
    run_en(1);
    check_eq("restart_pads", pads(), 3);
    check_eq("restart_seg", int'(seg), 0);
    run_en(14);
    check_eq("restart_seg@15", int'(seg), 0);
    run_en(1);
    check_eq("restart_seg@16", int'(seg), 1);
    check_eq("restart_tick@16", int'(seg_tick), 1);

    // Mode toggle at lvl=4 in seg0
    advance_to(0, 4);
    mode = 1'b1;
    count_lit(8, r, g, b);
    check_eq("mode_fade_g_lit", g, 4);
    mode = 1'b0;
    count_lit(8, r, g, b);
    check_eq("mode_step_g_lit", g, 0);
    check_eq("mode_step_r_lit", r, 8);
    en = 1'b1; n = 0;
    while (!seg_tick && n < 200) begin
      mode = ~mode;
      tick();
      n++;
    end
    check_eq("mode_tick_edges", n, 8);
    check_eq("mode_tick_seg", int'(seg), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/rgb_hue_seq.md
# rgb_hue_seq

Parametrised RGB LED colour sequencer for the iCE40 board, replacing the fixed-colour cycling FSM behind the top-level LED pads. Walks a six-segment hue wheel (red → yellow → green → cyan → blue → magenta → red) with configurable segment length and PWM resolution. Supports hard colour steps or smooth PWM crossfades, plus pause. Drives the active-low RGB pads directly.

## Interface

- `STEP_CYCLES`, default 7812: enabled clock cycles per duty increment. Must be ≥1. Segment length = `STEP_CYCLES`·2^`PWM_BITS`, about 1/6 s at 12 MHz with the defaults.
- `PWM_BITS`, default 8: PWM and ramp resolution. Allowed range 2..12.

- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: 1 = sequence advances, 0 = sequence frozen.
- `mode` in 1: 0 = STEP, 1 = FADE.
- `seg` out 3: current segment index, 0..5.
- `seg_tick` out 1: one-cycle pulse on every segment change.
- `RGB_R`, `RGB_G`, `RGB_B` out 1: active-low LED drives (0 = lit).

## Operation

- **Prescaler `pre`** (0..`STEP_CYCLES`-1):
  - Increments on each cycle with `en`=1.
  - At terminal count it wraps to 0 and increments level `lvl` (0..2^`PWM_BITS`-1).
- **Segment advance:** when `lvl` wraps from max to 0, `seg` advances. 5 wraps to 0.
- **Duty values:** each channel duty is `PWM_BITS`+1 bits wide. FULL = 2^`PWM_BITS`, which means always lit. OFF = 0.
- **FADE duties per segment:**
  - seg0: R=FULL, G=`lvl`, B=0.
  - seg1: R=FULL−`lvl`, G=FULL, B=0.
  - seg2: R=0, G=FULL, B=`lvl`.
  - seg3: R=0, G=FULL−`lvl`, B=FULL.
  - seg4: R=`lvl`, G=0, B=FULL.
  - seg5: R=FULL, G=0, B=FULL−`lvl`.
- **STEP duties:** each channel takes its FADE duty at `lvl`=0, so every channel is either FULL or 0. Colours are red, yellow, green, cyan, blue, magenta for seg0..5.
- **PWM:**
  - Free-running counter `pwm_cnt` (`PWM_BITS` wide) increments every cycle, regardless of `en`.
  - A channel is lit when duty > `pwm_cnt`.
  - Lit state is registered, and the pad is driven with its inverse.
- **`en`=0:**
  - `pre`, `lvl` and `seg` hold their values.
  - PWM keeps running, so the current colour keeps displaying.
  - `seg_tick` stays 0.
- **`mode` change:**
  - Affects duties combinationally, so it is visible on the pads 1 cycle later.
  - Never touches `pre`, `lvl` or `seg`.

## Timing

- **Reset (asynchronous, during `rst_n`=0):**
  - `pre`, `lvl`, `seg` and `pwm_cnt` = 0.
  - `seg_tick` = 0.
  - `RGB_R`, `RGB_G`, `RGB_B` = 1 (all dark).
- **After reset release:** the first clock edge registers seg0/`lvl`=0 duties, so `RGB_R`=0 from that edge.
- **Output latency:** pads lag `pwm_cnt`/duty by exactly 1 cycle.
- **`seg` and `seg_tick`:**
  - `seg` is registered.
  - `seg_tick`=1 in exactly the cycle in which `seg` first shows its new value.
- **Segment length:** exactly `STEP_CYCLES`·2^`PWM_BITS` enabled cycles. A full wheel is 6 times that.
- **`STEP_CYCLES`=1:** `lvl` increments on every enabled cycle.
- **Reset mid-sequence:** reset is asynchronous. Pads go high with no clock edge, and the sequence restarts at seg0 with `lvl`=0.
- **`en` falling:** if `en` falls in the same cycle `pre` would wrap, the wrap does not occur.

## Structure

- **Package `rgb_hue_pkg`** holds:
  - `seg_t` enum: SEG_RY, SEG_YG, SEG_GC, SEG_CB, SEG_BM, SEG_MR.
  - `NUM_SEGS`=6.
  - A function returning the three duties from (seg, lvl, mode, width).
- **Sub-module `pwm_gen`:**
  - Holds the shared `pwm_cnt` and the three registered comparators.
  - Outputs active-high lit signals.
  - `rgb_hue_seq` inverts them onto the pads.
- **Top level:** instantiates `rgb_hue_seq` with `en`=1 and `mode`=1.

## Test plan

All scenarios use `PWM_BITS`=3 and `STEP_CYCLES`=2, so a segment is 16 cycles.

1. **Reset:** hold `rst_n`=0 → all pads 1 and `seg`=0. Release with `mode`=0 → from the first edge, `RGB_R`=0, `RGB_G`=1, `RGB_B`=1.
2. **STEP sequence:** run 96 cycles.
   - `seg` goes 1,2,3,4,5,0 at cycles 16,32,…,96.
   - `seg_tick` pulses 6 times, each 1 cycle wide.
   - seg1 gives R=G=0, B=1. seg3 gives R=1, G=B=0.
3. **FADE duty:** in seg0 with `lvl`=3.
   - Over one 8-cycle PWM period, `RGB_G`=0 for exactly 3 cycles.
   - `RGB_R`=0 for all 8 cycles and `RGB_B`=1 for all 8.
   - In seg1 with `lvl`=3, `RGB_R`=0 for 5 of 8 cycles.
4. **Pause:** drop `en` for 40 cycles mid-seg2.
   - `seg` and `lvl` stay frozen and PWM continues.
   - Segment end arrives exactly 40 cycles later than nominal.
5. **Async reset mid-sequence:** assert `rst_n` mid-seg3 between clock edges → pads go to 1 before the next edge. After release, the sequence restarts at seg0.
6. **Mode toggle:** toggle `mode` at `lvl`=4 in seg0.
   - `RGB_G` duty switches between 4/8 and 0/8 one cycle later.
   - `seg_tick` timing is unchanged.
